sobel_edge3: RTL and testbench

- Downstream consumer of the 3-line tap buffer's 270-bit 3x3 window; computes a Sobel edge magnitude per pixel.
- Converts each of the 9 RGB taps to luma, forms Gx/Gy, then thresholds or passes through the magnitude.
- Result goes to the VGA/frame-writer path as a 30-bit RGB pixel with a valid strobe.
- 3-stage pipeline, advances only on clken (same stall semantics as the line buffer), with frame-position counters to blank border windows.

---
 rtl/sobel_edge3.sv | 153 +++++++++++++++
 tb/tb_sobel_edge3.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_edge3.sv
// Sobel edge detector for a 3x3 RGB window produced by the 3-line tap buffer.
// Pipeline: luma per tap -> signed Gx/Gy -> |Gx|+|Gy| saturate, threshold or grey.
// All stages advance together on clken. A frame-position counter marks border
// windows (col<2 or row<2), and those windows are forced to zero at the output.
module sobel_edge3 #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clken,
    input  logic         iSOF,
    input  logic [269:0] iGrid,
    input  logic [9:0]   iThreshold,
    input  logic         iBypass,
    output logic [29:0]  oPixel,
    output logic         oValid,
    output logic         oBorder
);

    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    // Frame position of the window currently on iGrid.
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          border_d;

    // Pipeline valid bits and border flags travelling with the data.
    logic v1_q, v2_q, v3_q;
    logic b1_q, b2_q;
    logic adv_q;

    // Datapath registers.
    logic [9:0]         luma_d [9];
    logic [9:0]         y_q    [9];
    logic signed [12:0] gx_d, gy_d;
    logic signed [12:0] gx_q, gy_q;

    // Output registers.
    logic [29:0] pixel_q, pixel_d;
    logic        border_q;

    // Position counter next state and border classification of the incoming window.
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        border_d = 1'b0;
        if (iSOF) begin
            border_d = 1'b1;
            col_d    = CW'(1);
            row_d    = '0;
        end else begin
            border_d = (col_q < CW'(2)) || (row_q < RW'(2));
            if (col_q == CW'(WIDTH - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(HEIGHT - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Stage 1 combinational: luma = (R + 2G + B) >> 2 for every tap.
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            logic [29:0] pix;
            logic [11:0] sum;
            pix       = iGrid[k*30 +: 30];
            sum       = {2'b00, pix[29:20]} + {1'b0, pix[19:10], 1'b0} + {2'b00, pix[9:0]};
            luma_d[k] = sum[11:2];
        end
    end

    // Stage 2 combinational: Sobel gradients. Results fit in 13 signed bits,
    // so modulo-2^13 arithmetic on the zero-extended lumas gives the exact value.
    always_comb begin
        logic [12:0] xp, xn, yp, yn;
        xp   = {3'b000, y_q[8]} + {2'b00, y_q[5], 1'b0} + {3'b000, y_q[2]};
        xn   = {3'b000, y_q[6]} + {2'b00, y_q[3], 1'b0} + {3'b000, y_q[0]};
        yp   = {3'b000, y_q[8]} + {2'b00, y_q[7], 1'b0} + {3'b000, y_q[6]};
        yn   = {3'b000, y_q[2]} + {2'b00, y_q[1], 1'b0} + {3'b000, y_q[0]};
        gx_d = signed'(xp - xn);
        gy_d = signed'(yp - yn);
    end

    // Stage 3 combinational: magnitude, saturation and output pixel selection.
    always_comb begin
        logic [12:0] ax, ay, mag;
        logic [9:0]  sat;
        ax  = gx_q[12] ? 13'(-gx_q) : 13'(gx_q);
        ay  = gy_q[12] ? 13'(-gy_q) : 13'(gy_q);
        mag = ax + ay;
        sat = (mag > 13'd1023) ? 10'd1023 : mag[9:0];
        pixel_d = '0;
        if (b2_q) begin
            pixel_d = '0;
        end else if (iBypass) begin
            pixel_d = {sat, sat, sat};
        end else if (sat >= iThreshold) begin
            pixel_d = 30'h3FFFFFFF;
        end
    end

    // Control state: counters, valid/border pipeline and the output registers.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            col_q    <= '0;
            row_q    <= '0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            b1_q     <= 1'b0;
            b2_q     <= 1'b0;
            adv_q    <= 1'b0;
            pixel_q  <= '0;
            border_q <= 1'b0;
        end else begin
            adv_q <= clken;
            if (clken) begin
                col_q <= col_d;
                row_q <= row_d;
                v1_q  <= 1'b1;
                v2_q  <= v1_q;
                v3_q  <= v2_q;
                b1_q  <= border_d;
                b2_q  <= b1_q;
                if (v2_q) begin
                    pixel_q  <= pixel_d;
                    border_q <= b2_q;
                end
            end
        end
    end

    // Datapath registers carry no reset; the valid bits alone decide whether they matter.
    // NOTE: wide data/array registers are deliberately left unreset -- clearing the valid pipeline discards them.
    always_ff @(posedge clock) begin
        if (clken) begin
            y_q  <= luma_d;
            gx_q <= gx_d;
            gy_q <= gy_d;
        end
    end

    assign oPixel  = pixel_q;
    assign oBorder = border_q;
    // Strobe only in the cycle after an advancing edge that loaded a valid result.
    assign oValid  = v3_q & adv_q;

endmodule

// File: tb/tb_sobel_edge3.sv
// Scoreboard bench for sobel_edge3: the driver pushes hand-computed expected
// pixels, a monitor pops and compares whenever oValid is seen.
module tb_sobel_edge3;

    localparam int W = 16;
    localparam int H = 6;

    logic         clock;
    logic         reset_n;
    logic         clken;
    logic         iSOF;
    logic [269:0] iGrid;
    logic [9:0]   iThreshold;
    logic         iBypass;
    logic [29:0]  oPixel;
    logic         oValid;
    logic         oBorder;

    sobel_edge3 #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .clken      (clken),
        .iSOF       (iSOF),
        .iGrid      (iGrid),
        .iThreshold (iThreshold),
        .iBypass    (iBypass),
        .oPixel     (oPixel),
        .oValid     (oValid),
        .oBorder    (oBorder)
    );

    localparam logic [29:0]  WHITE = 30'h3FFFFFFF;
    localparam logic [269:0] G_FLAT = {9{WHITE}};
    localparam logic [269:0] G_EDGE = {WHITE, 60'h0, WHITE, 60'h0, WHITE, 60'h0};
    localparam logic [269:0] G_DOT  = {240'h0, 10'd400, 10'd400, 10'd400};
    localparam logic [269:0] G_MID  = {30'h0, 10'd100, 10'd100, 10'd100, 210'h0};
    // Hand-derived saturated magnitudes for the grids above.
    localparam int S_FLAT = 0;
    localparam int S_EDGE = 1023;
    localparam int S_DOT  = 800;
    localparam int S_MID  = 200;

    typedef struct { int sat; logic brd; } pend_t;
    typedef struct { logic [29:0] pix; logic brd; } exp_t;

    pend_t pend[$];
    exp_t  sb[$];

    int total = 0;
    int bad   = 0;
    int mc = 0, mr = 0;
    logic [9:0] cur_thr = 10'd512;
    logic       cur_byp = 1'b0;
    logic       mon_rst, mon_ce;
    logic [29:0] prev_pix = '0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [29:0] exp_pix(input int sat, input logic brd,
                                            input logic [9:0] thr, input logic byp);
        logic [9:0] s;
        s = 10'(sat);
        if (brd)         return '0;
        else if (byp)    return {s, s, s};
        else if (s >= thr) return WHITE;
        else             return '0;
    endfunction

    // Issue one window on the next edge and advance the position model.
    task automatic send(input logic [269:0] g, input int sat, input logic sof);
        pend_t p;
        exp_t  e;
        logic  brd;
        @(negedge clock);
        reset_n    = 1'b1;
        clken      = 1'b1;
        iSOF       = sof;
        iGrid      = g;
        iThreshold = cur_thr;
        iBypass    = cur_byp;
        if (sof) begin
            brd = 1'b1;
            mc  = 1;
            mr  = 0;
        end else begin
            brd = (mc < 2) || (mr < 2);
            if (mc == W - 1) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end else begin
                mc = mc + 1;
            end
        end
        pend.push_back('{sat: sat, brd: brd});
        // The window issued two edges ago reaches stage 3 at this edge.
        if (pend.size() == 3) begin
            p = pend.pop_front();
            e.pix = exp_pix(p.sat, p.brd, cur_thr, cur_byp);
            e.brd = p.brd;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            clken = 1'b0;
            iSOF  = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        clken   = 1'b1;
        iSOF    = 1'b0;
        pend.delete();
        sb.delete();
        mc = 0;
        mr = 0;
    endtask

    // Monitor: compares on every oValid and checks hold/reset behaviour.
    always @(posedge clock) begin
        mon_rst = reset_n;
        mon_ce  = clken;
        #1;
        if (!mon_rst) begin
            check("reset_valid",  {31'b0, oValid},  32'd0);
            check("reset_pixel",  {2'b0, oPixel},   32'd0);
            check("reset_border", {31'b0, oBorder}, 32'd0);
        end else if (!mon_ce) begin
            check("stall_valid", {31'b0, oValid}, 32'd0);
            check("stall_hold",  {2'b0, oPixel},  {2'b0, prev_pix});
        end else if (oValid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got oValid=1 expected no output at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pixel",  {2'b0, oPixel},   {2'b0, e.pix});
                check("border", {31'b0, oBorder}, {31'b0, e.brd});
            end
        end
        prev_pix = oPixel;
    end

    initial begin
        reset_n    = 1'b0;
        clken      = 1'b0;
        iSOF       = 1'b0;
        iGrid      = '0;
        iThreshold = 10'd512;
        iBypass    = 1'b0;
        repeat (3) @(posedge clock);

        // Flat frame start: rows 0-1 are border, (2,2) onward flat gives 0.
        cur_thr = 10'd512;
        cur_byp = 1'b0;
        send(G_FLAT, S_FLAT, 1'b1);
        for (int i = 1; i < 48; i++) send(G_FLAT, S_FLAT, 1'b0);

        // Vertical edge: binary white, then grey bypass.
        for (int i = 0; i < 6; i++) send(G_EDGE, S_EDGE, 1'b0);
        cur_byp = 1'b1;
        for (int i = 0; i < 4; i++) send(G_EDGE, S_EDGE, 1'b0);

        // Single corner tap, magnitude 800 against thresholds around it.
        for (int i = 0; i < 3; i++) send(G_DOT, S_DOT, 1'b0);
        cur_byp = 1'b0;
        cur_thr = 10'd801;
        for (int i = 0; i < 3; i++) send(G_DOT, S_DOT, 1'b0);
        cur_thr = 10'd800;
        for (int i = 0; i < 3; i++) send(G_DOT, S_DOT, 1'b0);

        // Magnitude 200 exactly at and just below threshold.
        cur_thr = 10'd200;
        for (int i = 0; i < 3; i++) send(G_MID, S_MID, 1'b0);
        cur_thr = 10'd201;
        for (int i = 0; i < 3; i++) send(G_MID, S_MID, 1'b0);

        // Stall for five cycles mid-stream, then zero threshold on flat input.
        idle(5);
        cur_thr = 10'd0;
        for (int i = 0; i < 4; i++) send(G_FLAT, S_FLAT, 1'b0);
        idle(2);

        // Run through the frame wrap; windows after it are border again.
        cur_thr = 10'd512;
        for (int i = 0; i < 100; i++) begin
            send((i % 2 == 0) ? G_EDGE : G_DOT, (i % 2 == 0) ? S_EDGE : S_DOT, 1'b0);
            if (mc == 4 && mr == 0) break;
        end
        for (int i = 0; i < 20; i++) send(G_EDGE, S_EDGE, 1'b0);

        // Mid-frame SOF: in-flight windows keep their flags, new ones restart at (0,0).
        send(G_EDGE, S_EDGE, 1'b1);
        for (int i = 0; i < 3; i++) send(G_EDGE, S_EDGE, 1'b0);

        // One-cycle reset mid-stream, then resume without SOF.
        do_reset();
        for (int i = 0; i < 40; i++) send(G_EDGE, S_EDGE, 1'b0);

        // Drain: everything expected must have been seen.
        idle(4);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
